// File: rtl/sparse_weight_csr_encoder.sv
// Streams dense KxK kernels in row-major order and emits the nonzeros (value/row/col)
// followed by one packed CSR row-pointer word per kernel.
module sparse_weight_csr_encoder #(
    parameter int DW          = 8,
    parameter int K           = 5,
    parameter int NUM_KERNELS = 102
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [DW-1:0]        in_data,
    output logic                 in_ready,
    output logic                 nz_valid,
    output logic [DW-1:0]        nz_data,
    output logic [3:0]           nz_row,
    output logic [3:0]           nz_col,
    input  logic                 nz_ready,
    output logic                 rp_valid,
    output logic [8*(K+1)-1:0]   rp_word,
    output logic [6:0]           rp_addr,
    input  logic                 rp_ready
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    localparam logic [3:0] KM1       = 4'(K - 1);
    localparam logic [6:0] LAST_ADDR = 7'(NUM_KERNELS - 1);

    logic [0:0] state;
    logic [3:0] row;
    logic [3:0] col;
    logic [7:0] cnt;
    logic [7:0] cnt_next;
    logic [7:0] rp_q [1:K];
    logic       accept;
    logic       is_nz;
    logic       row_end;

    assign in_ready = !rst && (state == RUN) && (!nz_valid || nz_ready);
    // Holding the word back until the nz register drains keeps nonzeros ahead of their pointer.
    assign rp_valid = !rst && (state == EMIT) && !nz_valid;

    assign accept   = in_valid && in_ready;
    assign is_nz    = (in_data != '0);
    assign cnt_next = cnt + {7'd0, is_nz};
    assign row_end  = (col == KM1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            row      <= 4'd0;
            col      <= 4'd0;
            cnt      <= 8'd0;
            rp_addr  <= 7'd0;
            nz_valid <= 1'b0;
            nz_data  <= '0;
            nz_row   <= 4'd0;
            nz_col   <= 4'd0;
            for (int i = 1; i <= K; i++) rp_q[i] <= 8'd0;
        end else begin
            if (accept && is_nz) begin
                nz_valid <= 1'b1;
                nz_data  <= in_data;
                nz_row   <= row;
                nz_col   <= col;
            end else if (nz_ready) begin
                nz_valid <= 1'b0;
            end

            if (accept) begin
                cnt <= cnt_next;
                if (row_end) begin
                    col <= 4'd0;
                    row <= row + 4'd1;
                    // Row pointer entry row+1 captures the count including this element.
                    for (int i = 1; i <= K; i++)
                        if (row + 4'd1 == 4'(i)) rp_q[i] <= cnt_next;
                    if (row == KM1) state <= EMIT;
                end else begin
                    col <= col + 4'd1;
                end
            end

            if (rp_valid && rp_ready) begin
                state   <= RUN;
                cnt     <= 8'd0;
                row     <= 4'd0;
                col     <= 4'd0;
                rp_addr <= (rp_addr == LAST_ADDR) ? 7'd0 : rp_addr + 7'd1;
            end
        end
    end

    // rp[0] is always zero and sits in the top byte; rp[K] (total nnz) is the low byte.
    assign rp_word[8*K +: 8] = 8'd0;
    for (genvar g = 1; g <= K; g++) begin : g_pack
        assign rp_word[8*(K-g) +: 8] = rp_q[g];
    end

endmodule

// File: tb/tb_sparse_weight_csr_encoder.sv
// Directed bench for sparse_weight_csr_encoder at K=5: zero/sparse/dense kernels,
// backpressure on both outputs, rp_addr wrap and mid-kernel reset.
module tb_sparse_weight_csr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        nz_valid;
    logic [7:0]  nz_data;
    logic [3:0]  nz_row;
    logic [3:0]  nz_col;
    logic        nz_ready;
    logic        rp_valid;
    logic [47:0] rp_word;
    logic [6:0]  rp_addr;
    logic        rp_ready;

    sparse_weight_csr_encoder #(.DW(8), .K(5), .NUM_KERNELS(102)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .nz_valid(nz_valid), .nz_data(nz_data), .nz_row(nz_row), .nz_col(nz_col),
        .nz_ready(nz_ready),
        .rp_valid(rp_valid), .rp_word(rp_word), .rp_addr(rp_addr), .rp_ready(rp_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] nzq   [$];
    logic [47:0] rpq   [$];
    logic [6:0]  addrq [$];

    // Inputs only change on the falling edge, so a handshake seen here completes at the next rise.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (nz_valid && nz_ready) nzq.push_back({nz_data, nz_row, nz_col});
            if (rp_valid && rp_ready) begin
                rpq.push_back(rp_word);
                addrq.push_back(rp_addr);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the element is accepted.
    task automatic push(input logic [7:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $error("FAIL push_timeout observed=0 expected=1");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic push_kernel(input logic [7:0] kv [25]);
        for (int e = 0; e < 25; e++) push(kv[e]);
    endtask

    task automatic wait_rp(input int n);
        int c = 0;
        do begin
            @(negedge clk);
            #2;
            c++;
        end while (rpq.size() < n && c < 200);
        if (rpq.size() < n) begin
            checks++;
            errors++;
            $error("FAIL rp_timeout observed=%0d expected=%0d", rpq.size(), n);
        end
        @(negedge clk);
    endtask

    logic [7:0]  kz  [25];
    logic [7:0]  ks  [25];
    logic [7:0]  kd  [25];
    logic [7:0]  kb  [25];
    logic [15:0] exp_s [6];
    time         t0;
    int          bad;
    int          n0;

    initial begin
        for (int e = 0; e < 25; e++) begin
            kz[e] = 8'h00;
            ks[e] = 8'h00;
            kd[e] = 8'h01;
            kb[e] = 8'(e + 1);
        end
        // row nnz counts 1,3,0,1,1
        ks[2] = 8'h11; ks[5] = 8'h21; ks[6] = 8'h22; ks[9] = 8'h25; ks[18] = 8'h43; ks[24] = 8'h55;
        exp_s[0] = 16'h1102; exp_s[1] = 16'h2110; exp_s[2] = 16'h2211;
        exp_s[3] = 16'h2514; exp_s[4] = 16'h4333; exp_s[5] = 16'h5544;

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; nz_ready = 1'b1; rp_ready = 1'b1;

        // Reset
        repeat (2) @(negedge clk);
        #1;
        chk("in_reset_ready_valids", {in_ready, nz_valid, rp_valid}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_reset_in_ready", in_ready, 1'b1);
        chk("post_reset_nz", {nz_valid, nz_data, nz_row, nz_col}, 17'h0);
        chk("post_reset_rp", {rp_valid, rp_word, rp_addr}, 56'h0);
        @(negedge clk);

        // All-zero kernel
        push_kernel(kz);
        #1;
        chk("zero_rp_valid_latency", rp_valid, 1'b1);
        chk("zero_rp_word", rp_word, 48'h0);
        chk("zero_rp_addr", rp_addr, 7'd0);
        wait_rp(1);
        chk("zero_no_nz", nzq.size(), 0);
        chk("zero_emit_one_cycle", in_ready, 1'b1);

        // Sparse kernel
        nzq.delete();
        push_kernel(ks);
        wait_rp(2);
        chk("sparse_nz_count", nzq.size(), 6);
        for (int i = 0; i < 6; i++) chk($sformatf("sparse_nz%0d", i), nzq[i], exp_s[i]);
        chk("sparse_rp_word", rpq[1], 48'h000104040506);
        chk("sparse_rp_addr", addrq[1], 7'd1);

        // Dense kernel, back-to-back acceptance
        nzq.delete();
        t0 = $time;
        push_kernel(kd);
        chk("dense_cycles", $time - t0, 250);
        wait_rp(3);
        chk("dense_nz_count", nzq.size(), 25);
        for (int e = 0; e < 25; e++)
            chk($sformatf("dense_nz%0d", e), nzq[e], {8'h01, 4'(e / 5), 4'(e % 5)});
        chk("dense_rp_word", rpq[2], 48'h00050A0F1419);
        chk("dense_rp_addr", addrq[2], 7'd2);

        // Backpressure on nz mid-kernel, then on rp at the end
        nzq.delete();
        for (int e = 0; e < 7; e++) push(kb[e]);
        nz_ready = 1'b0;
        in_valid = 1'b1;
        in_data  = kb[7];
        #1;
        chk("bp_in_ready_drop", in_ready, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            chk("bp_nz_stable", {nz_valid, in_ready, nz_data, nz_row, nz_col},
                {1'b1, 1'b0, 8'd7, 4'd1, 4'd1});
        end
        @(negedge clk);
        nz_ready = 1'b1;
        for (int e = 7; e < 25; e++) push(kb[e]);
        nz_ready = 1'b0;
        rp_ready = 1'b0;
        #1;
        chk("bp_rp_wait_nz", {rp_valid, nz_valid}, 2'b01);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("bp_rp_still_wait", {rp_valid, nz_valid}, 2'b01);
        end
        @(negedge clk);
        nz_ready = 1'b1;
        #1;
        chk("bp_rp_drain_cycle", rp_valid, 1'b0);
        @(negedge clk);
        nz_ready = 1'b0;
        #1;
        chk("bp_rp_after_drain", {rp_valid, rp_word, rp_addr}, {1'b1, 48'h00050A0F1419, 7'd3});
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("bp_rp_hold", {rp_valid, rp_word, rp_addr}, {1'b1, 48'h00050A0F1419, 7'd3});
        end
        @(negedge clk);
        rp_ready = 1'b1;
        nz_ready = 1'b1;
        wait_rp(4);
        chk("bp_nz_count", nzq.size(), 25);
        chk("bp_nz_last", nzq[24], {8'd25, 4'd4, 4'd4});
        chk("bp_nz_stalled_elem", nzq[6], {8'd7, 4'd1, 4'd1});

        // rp_addr wrap across 103 kernels total
        for (int k = 0; k < 99; k++) begin
            push_kernel(kz);
            wait_rp(5 + k);
        end
        chk("wrap_count", addrq.size(), 103);
        bad = 0;
        for (int i = 0; i < addrq.size(); i++) if (addrq[i] !== 7'(i % 102)) bad++;
        chk("wrap_sequence", bad, 0);
        chk("wrap_addr101", addrq[101], 7'd101);
        chk("wrap_addr102", addrq[102], 7'd0);

        // Reset after 13 elements
        for (int e = 0; e < 13; e++) push(8'h01);
        rst = 1'b1;
        #1;
        chk("rst_comb_outputs", {in_ready, rp_valid}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_nz", {nz_valid, nz_data, nz_row, nz_col}, 17'h0);
        chk("rst_rp", {rp_valid, rp_word, rp_addr}, 56'h0);
        @(negedge clk);
        n0 = rpq.size();
        chk("rst_no_partial_word", n0, 103);
        push_kernel(kd);
        wait_rp(n0 + 1);
        chk("rst_dense_rp_word", rpq[n0], 48'h00050A0F1419);
        chk("rst_dense_rp_addr", addrq[n0], 7'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
